// File: rtl/mac_mxfp_if.sv
// Operand/result bundle for the MX block MAC.
// Streamer side is master, MAC side is slave.
interface mac_mxfp_if #(
    parameter int EXP_WIDTH = 2,
    parameter int MAN_WIDTH = 1,
    parameter int ACC_WIDTH = 16
);
    localparam int ELEM_W = 1 + EXP_WIDTH + MAN_WIDTH;

    logic                        clear;
    logic                        in_valid;
    logic [ELEM_W-1:0]           w_elem;
    logic [ELEM_W-1:0]           a_elem;
    logic [7:0]                  w_scale;
    logic [7:0]                  a_scale;
    logic                        busy;
    logic                        out_valid;
    logic signed [ACC_WIDTH-1:0] out_sum;
    logic signed [9:0]           out_scale;
    logic                        out_nan;
    logic                        out_ovf;

    modport master (
        output clear, in_valid, w_elem, a_elem, w_scale, a_scale,
        input  busy, out_valid, out_sum, out_scale, out_nan, out_ovf
    );

    modport slave (
        input  clear, in_valid, w_elem, a_elem, w_scale, a_scale,
        output busy, out_valid, out_sum, out_scale, out_nan, out_ovf
    );
endinterface

// File: rtl/mac_mxfp_block.sv
// MX block MAC: accumulates one block of element products with
// saturation and forwards the combined E8M0 exponent with the sum.
module mac_mxfp_block #(
    parameter int EXP_WIDTH  = 2,
    parameter int MAN_WIDTH  = 1,
    parameter int BLOCK_SIZE = 32,
    parameter int ACC_WIDTH  = 16
) (
    input  logic       clk,
    input  logic       reset,
    mac_mxfp_if.slave  bus
);
    localparam int ELEM_W     = 1 + EXP_WIDTH + MAN_WIDTH;
    localparam int FRAC_WIDTH = MAN_WIDTH + 1;
    localparam int PROD_WIDTH = 2 * FRAC_WIDTH + 2 ** EXP_WIDTH;
    localparam int CNT_W      = $clog2(BLOCK_SIZE);
    localparam int SUM_W      =
        ((ACC_WIDTH > PROD_WIDTH + 1) ? ACC_WIDTH : PROD_WIDTH + 1) + 1;

    localparam logic signed [SUM_W-1:0] ACC_MAX =
        {{(SUM_W-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] ACC_MIN = ~ACC_MAX;

    logic [CNT_W-1:0]            cnt;

    logic                        s1_valid;
    logic                        s1_first;
    logic                        s1_last;
    logic [ELEM_W-1:0]           s1_w;
    logic [ELEM_W-1:0]           s1_a;
    logic signed [9:0]           s1_scale;
    logic                        s1_nan;

    logic                        s2_valid;
    logic                        s2_first;
    logic                        s2_last;
    logic signed [PROD_WIDTH:0]  s2_prod;
    logic signed [9:0]           s2_scale;
    logic                        s2_nan;

    logic signed [ACC_WIDTH-1:0] acc;
    logic                        ovf;
    logic signed [9:0]           blk_scale;
    logic                        blk_nan;

    logic [EXP_WIDTH-1:0]        w_exp;
    logic [EXP_WIDTH-1:0]        a_exp;
    logic [FRAC_WIDTH-1:0]       w_frac;
    logic [FRAC_WIDTH-1:0]       a_frac;
    logic [EXP_WIDTH-1:0]        w_sh;
    logic [EXP_WIDTH-1:0]        a_sh;
    logic [EXP_WIDTH:0]          sh;
    logic [2*FRAC_WIDTH-1:0]     frac_prod;
    logic [PROD_WIDTH-1:0]       mag;
    logic signed [PROD_WIDTH:0]  prod;

    logic signed [SUM_W-1:0]     base;
    logic signed [SUM_W-1:0]     sum;
    logic                        sat_hi;
    logic                        sat_lo;
    logic signed [ACC_WIDTH-1:0] acc_next;
    logic                        ovf_next;
    logic signed [9:0]           scale_in;
    logic                        nan_in;
    logic                        cnt_first;
    logic                        cnt_last;

    assign bus.busy  = (cnt != '0);
    assign cnt_first = (cnt == '0);
    assign cnt_last  = (cnt == CNT_W'(BLOCK_SIZE - 1));

    assign scale_in = $signed({2'b00, bus.w_scale})
                    + $signed({2'b00, bus.a_scale})
                    - 10'sd254;
    assign nan_in   = (bus.w_scale == 8'hFF) || (bus.a_scale == 8'hFF);

    // Subnormals have no hidden bit and share the exponent-1 shift.
    always_comb begin
        w_exp  = s1_w[MAN_WIDTH +: EXP_WIDTH];
        a_exp  = s1_a[MAN_WIDTH +: EXP_WIDTH];
        w_frac = {(w_exp != '0), s1_w[MAN_WIDTH-1:0]};
        a_frac = {(a_exp != '0), s1_a[MAN_WIDTH-1:0]};
        w_sh   = (w_exp == '0) ? '0 : w_exp - EXP_WIDTH'(1);
        a_sh   = (a_exp == '0) ? '0 : a_exp - EXP_WIDTH'(1);
        sh     = {1'b0, w_sh} + {1'b0, a_sh};
        frac_prod = {{FRAC_WIDTH{1'b0}}, w_frac}
                  * {{FRAC_WIDTH{1'b0}}, a_frac};
        mag    = {{(PROD_WIDTH-2*FRAC_WIDTH){1'b0}}, frac_prod} << sh;
        if (s1_w[ELEM_W-1] ^ s1_a[ELEM_W-1])
            prod = -$signed({1'b0, mag});
        else
            prod = $signed({1'b0, mag});
    end

    // A first-tagged product restarts the block instead of adding.
    always_comb begin
        base     = s2_first ? '0 : SUM_W'(acc);
        sum      = base + SUM_W'(s2_prod);
        sat_hi   = (sum > ACC_MAX);
        sat_lo   = (sum < ACC_MIN);
        acc_next = sum[ACC_WIDTH-1:0];
        if (sat_hi)
            acc_next = ACC_MAX[ACC_WIDTH-1:0];
        else if (sat_lo)
            acc_next = ACC_MIN[ACC_WIDTH-1:0];
        ovf_next = (s2_first ? 1'b0 : ovf) | sat_hi | sat_lo;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt           <= '0;
            s1_valid      <= 1'b0;
            s1_first      <= 1'b0;
            s1_last       <= 1'b0;
            s1_w          <= '0;
            s1_a          <= '0;
            s1_scale      <= '0;
            s1_nan        <= 1'b0;
            s2_valid      <= 1'b0;
            s2_first      <= 1'b0;
            s2_last       <= 1'b0;
            s2_prod       <= '0;
            s2_scale      <= '0;
            s2_nan        <= 1'b0;
            acc           <= '0;
            ovf           <= 1'b0;
            blk_scale     <= '0;
            blk_nan       <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_sum   <= '0;
            bus.out_scale <= '0;
            bus.out_nan   <= 1'b0;
            bus.out_ovf   <= 1'b0;
        end else begin
            bus.out_valid <= 1'b0;
            if (bus.clear) begin
                cnt      <= '0;
                s1_valid <= 1'b0;
                s2_valid <= 1'b0;
                acc      <= '0;
                ovf      <= 1'b0;
            end else begin
                s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    cnt      <= cnt + CNT_W'(1);
                    s1_w     <= bus.w_elem;
                    s1_a     <= bus.a_elem;
                    s1_first <= cnt_first;
                    s1_last  <= cnt_last;
                    if (cnt_first) begin
                        s1_scale <= scale_in;
                        s1_nan   <= nan_in;
                    end
                end

                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_prod  <= prod;
                    s2_first <= s1_first;
                    s2_last  <= s1_last;
                    if (s1_first) begin
                        s2_scale <= s1_scale;
                        s2_nan   <= s1_nan;
                    end
                end

                if (s2_valid) begin
                    acc <= acc_next;
                    ovf <= ovf_next;
                    if (s2_first) begin
                        blk_scale <= s2_scale;
                        blk_nan   <= s2_nan;
                    end
                    if (s2_last) begin
                        bus.out_valid <= 1'b1;
                        bus.out_sum   <= acc_next;
                        bus.out_ovf   <= ovf_next;
                        bus.out_scale <= s2_first ? s2_scale : blk_scale;
                        bus.out_nan   <= s2_first ? s2_nan : blk_nan;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_mac_mxfp_block.sv
// Bench for mac_mxfp_block: E2M1, 4-element blocks, two accumulator
// widths driven in lockstep and checked against a real-valued model.
module tb_mac_mxfp_block;
    localparam int E    = 2;
    localparam int M    = 1;
    localparam int B    = 4;
    localparam int EW   = 1 + E + M;
    localparam int BIAS = 2 ** (E - 1) - 1;

    typedef logic [EW-1:0] elem_t;
    typedef struct {
        logic signed [63:0] sum;
        logic signed [63:0] scale;
        logic               nan;
        logic               ovf;
        int                 cyc;
    } res_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mac_mxfp_if #(.EXP_WIDTH(E), .MAN_WIDTH(M), .ACC_WIDTH(16)) b16 ();
    mac_mxfp_if #(.EXP_WIDTH(E), .MAN_WIDTH(M), .ACC_WIDTH(10)) b10 ();

    mac_mxfp_block #(
        .EXP_WIDTH(E), .MAN_WIDTH(M), .BLOCK_SIZE(B), .ACC_WIDTH(16)
    ) dut16 (.clk(clk), .reset(reset), .bus(b16.slave));

    mac_mxfp_block #(
        .EXP_WIDTH(E), .MAN_WIDTH(M), .BLOCK_SIZE(B), .ACC_WIDTH(10)
    ) dut10 (.clk(clk), .reset(reset), .bus(b10.slave));

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    res_t q16[$], q10[$], e16[$], e10[$];
    res_t last16, last10;
    elem_t bw[B], ba[B];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (b16.out_valid === 1'b1)
            q16.push_back('{b16.out_sum, b16.out_scale,
                            b16.out_nan, b16.out_ovf, cyc});
        if (b10.out_valid === 1'b1)
            q10.push_back('{b10.out_sum, b10.out_scale,
                            b10.out_nan, b10.out_ovf, cyc});
    end

    task automatic chk(input string tag,
                       input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Element real value straight from the MX format definition.
    function automatic real elem_val(input elem_t e);
        int  ex;
        int  mm;
        real v;
        ex = int'(e[M +: E]);
        mm = int'(e[M-1:0]);
        if (ex == 0)
            v = (2.0 ** (1 - BIAS)) * (real'(mm) / (2.0 ** M));
        else
            v = (2.0 ** (ex - BIAS)) * (1.0 + real'(mm) / (2.0 ** M));
        if (e[EW-1]) v = -v;
        return v;
    endfunction

    task automatic model(input int accw, output longint s, output bit ov);
        longint hi, lo, p;
        real    unit;
        unit = 2.0 ** (2 * M - 2 * (1 - BIAS));
        hi = (longint'(1) <<< (accw - 1)) - 1;
        lo = -hi - 1;
        s  = 0;
        ov = 1'b0;
        for (int i = 0; i < B; i++) begin
            p = longint'(elem_val(bw[i]) * elem_val(ba[i]) * unit);
            s = (i == 0) ? p : s + p;
            if (s > hi) begin s = hi; ov = 1'b1; end
            else if (s < lo) begin s = lo; ov = 1'b1; end
        end
    endtask

    task automatic drive(input elem_t w, input elem_t a,
                         input logic [7:0] ws, input logic [7:0] as,
                         input logic clr);
        b16.in_valid = 1'b1; b10.in_valid = 1'b1;
        b16.clear = clr;     b10.clear = clr;
        b16.w_elem = w;      b10.w_elem = w;
        b16.a_elem = a;      b10.a_elem = a;
        b16.w_scale = ws;    b10.w_scale = ws;
        b16.a_scale = as;    b10.a_scale = as;
        @(posedge clk);
        #1;
        b16.in_valid = 1'b0; b10.in_valid = 1'b0;
        b16.clear = 1'b0;    b10.clear = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_block(input bit ff_noise, input int gap_pos,
                              input int gap_len, input logic [7:0] ws,
                              input logic [7:0] as, input string tag);
        logic [7:0] nws, nas;
        longint     s;
        bit         ov;
        res_t       r;
        for (int i = 0; i < B; i++) begin
            if (i == gap_pos && i > 0) begin
                for (int g = 0; g < gap_len; g++) begin
                    chk({tag, "_busy_gap"}, b16.busy, 1);
                    idle(1);
                end
            end
            nws = ff_noise ? 8'hFF : 8'($urandom);
            nas = ff_noise ? 8'hFF : 8'($urandom);
            if (i == 0) begin nws = ws; nas = as; end
            drive(bw[i], ba[i], nws, nas, 1'b0);
        end
        r.scale = int'(ws) + int'(as) - 254;
        r.nan   = (ws == 8'hFF) || (as == 8'hFF);
        r.cyc   = cyc + 2;
        model(16, s, ov); r.sum = s; r.ovf = ov; e16.push_back(r);
        model(10, s, ov); r.sum = s; r.ovf = ov; e10.push_back(r);
    endtask

    task automatic check_results(input string tag);
        res_t o, x;
        idle(3);
        chk({tag, "_cnt16"}, q16.size(), e16.size());
        chk({tag, "_cnt10"}, q10.size(), e10.size());
        while (q16.size() > 0 && e16.size() > 0) begin
            o = q16.pop_front(); x = e16.pop_front(); last16 = o;
            chk({tag, "_sum16"}, o.sum, x.sum);
            chk({tag, "_scale16"}, o.scale, x.scale);
            chk({tag, "_nan16"}, o.nan, x.nan);
            chk({tag, "_ovf16"}, o.ovf, x.ovf);
            chk({tag, "_lat16"}, o.cyc, x.cyc);
        end
        while (q10.size() > 0 && e10.size() > 0) begin
            o = q10.pop_front(); x = e10.pop_front(); last10 = o;
            chk({tag, "_sum10"}, o.sum, x.sum);
            chk({tag, "_ovf10"}, o.ovf, x.ovf);
        end
        q16.delete(); q10.delete(); e16.delete(); e10.delete();
    endtask

    task automatic fill(input elem_t w, input elem_t a);
        for (int i = 0; i < B; i++) begin bw[i] = w; ba[i] = a; end
    endtask

    task automatic fill_rand();
        for (int i = 0; i < B; i++) begin
            bw[i] = elem_t'($urandom);
            ba[i] = elem_t'($urandom);
        end
    endtask

    initial begin
        last16 = '{-999, -999, 1'bx, 1'bx, -1};
        last10 = last16;
        b16.clear = 1'b0; b10.clear = 1'b0;
        b16.in_valid = 1'b0; b10.in_valid = 1'b0;
        b16.w_elem = '0; b10.w_elem = '0;
        b16.a_elem = '0; b10.a_elem = '0;
        b16.w_scale = '0; b10.w_scale = '0;
        b16.a_scale = '0; b10.a_scale = '0;

        // asynchronous reset before the first clock edge
        #2 reset = 1'b0;
        #2;
        chk("rst_valid", b16.out_valid, 0);
        chk("rst_sum", b16.out_sum, 0);
        chk("rst_scale", b16.out_scale, 0);
        chk("rst_nan", b16.out_nan, 0);
        chk("rst_ovf", b16.out_ovf, 0);
        chk("rst_busy", b16.busy, 0);
        chk("rst_sum10", b10.out_sum, 0);
        idle(2);
        reset = 1'b1;
        idle(1);

        // 4 x (6.0 * 6.0), both accumulator widths
        fill(4'b0111, 4'b0111);
        send_block(1'b0, 0, 0, 8'd127, 8'd127, "six");
        check_results("six");
        chk("six_sum16_const", last16.sum, 576);
        chk("six_scale_const", last16.scale, 0);
        chk("six_ovf16_const", last16.ovf, 0);
        chk("sat_sum10_const", last10.sum, 511);
        chk("sat_ovf10_const", last10.ovf, 1);

        // signs and a subnormal
        bw[0] = 4'b0111; ba[0] = 4'b0111;
        bw[1] = 4'b1111; ba[1] = 4'b0111;
        bw[2] = 4'b0010; ba[2] = 4'b0010;
        bw[3] = 4'b0001; ba[3] = 4'b0010;
        send_block(1'b0, 0, 0, 8'd127, 8'd127, "sign");
        check_results("sign");
        chk("sign_sum_const", last16.sum, 6);
        chk("sign_nan_const", last16.nan, 0);

        // scales taken from the first element only
        fill_rand();
        send_block(1'b1, 0, 0, 8'd130, 8'd120, "scl1");
        check_results("scl1");
        chk("scl1_scale_const", last16.scale, -4);
        chk("scl1_nan_const", last16.nan, 0);
        fill_rand();
        send_block(1'b0, 0, 0, 8'hFF, 8'd127, "scl2");
        check_results("scl2");
        chk("scl2_nan_const", last16.nan, 1);

        // gap inside block 1, block 2 back-to-back
        fill_rand();
        send_block(1'b0, $urandom_range(1, B - 1), 3,
                   8'($urandom_range(100, 150)), 8'd127, "gap1");
        chk("gap_busy_between", b16.busy, 0);
        fill_rand();
        send_block(1'b0, 0, 0, 8'd127, 8'($urandom_range(100, 150)), "gap2");
        check_results("gap");

        // clear after two elements; clear with in_valid drops it
        fill(4'b0010, 4'b0010);
        drive(4'b0111, 4'b0111, 8'd127, 8'd127, 1'b0);
        drive(4'b0111, 4'b0111, 8'd127, 8'd127, 1'b0);
        drive(4'b0111, 4'b0111, 8'd127, 8'd127, 1'b1);
        chk("clr_busy", b16.busy, 0);
        send_block(1'b0, 0, 0, 8'd127, 8'd127, "clr");
        check_results("clr");
        chk("clr_sum_const", last16.sum, 16);

        // reset mid-block
        drive(4'b0111, 4'b0111, 8'd130, 8'd127, 1'b0);
        drive(4'b0111, 4'b0111, 8'd130, 8'd127, 1'b0);
        reset = 1'b0;
        #1;
        chk("mrst_sum", b16.out_sum, 0);
        chk("mrst_scale", b16.out_scale, 0);
        chk("mrst_busy", b16.busy, 0);
        chk("mrst_valid", b16.out_valid, 0);
        #1 reset = 1'b1;
        idle(1);
        fill_rand();
        send_block(1'b0, 0, 0, 8'd128, 8'd126, "post");
        check_results("post");

        // random back-to-back blocks with random gaps
        for (int r = 0; r < 24; r++) begin
            fill_rand();
            send_block(1'b0, $urandom_range(0, B - 1), $urandom_range(0, 3),
                       ($urandom_range(0, 7) == 0) ? 8'hFF
                                                   : 8'($urandom_range(90, 160)),
                       8'($urandom_range(90, 160)), "rnd");
        end
        check_results("rnd");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mac_mxfp_block.md
Name: mac_mxfp_block

Overview:
- Parametrised successor to the single-format fp4 MAC.
- Accumulates BLOCK_SIZE element products of one MX block.
  - Configurable element format (EXP_WIDTH/MAN_WIDTH covers E2M1, E2M3, E3M2).
  - Carries the two shared E8M0 block scales alongside the sum.
- Emits one (sum, combined exponent) result per block with a valid pulse.
- Sits between the operand streamers and the block-level reduction/normalisation stage.

Parameters:
- EXP_WIDTH, 2: element exponent bits.
- MAN_WIDTH, 1: element mantissa bits.
- BLOCK_SIZE, 32: elements per MX block (power of two, >=2).
- ACC_WIDTH, 16: signed block accumulator width. Must be >= PROD_WIDTH+1+log2(BLOCK_SIZE) for wrap-free worst case; smaller values saturate.
- Derived: FRAC_WIDTH = MAN_WIDTH+1.
- Derived: PROD_WIDTH = 2*FRAC_WIDTH + 2**EXP_WIDTH.
- Derived: BIAS = 2**(EXP_WIDTH-1)-1.

Ports:
- clk, in, 1: clock, all state on rising edge.
- reset, in, 1: asynchronous, active-low reset.
- clear, in, 1: synchronous abort of the current block. Flushes the pipeline, counter and accumulator.
- in_valid, in, 1: element pair accepted this cycle. No backpressure.
- w_elem, in, 1+EXP_WIDTH+MAN_WIDTH: weight element, {sign, exp, man}.
- a_elem, in, 1+EXP_WIDTH+MAN_WIDTH: activation element, {sign, exp, man}.
- w_scale, in, 8: weight block scale, E8M0.
- a_scale, in, 8: activation block scale, E8M0.
- busy, out, 1: high while a block is partially accepted (element count != 0).
- out_valid, out, 1: one-cycle pulse, block result valid.
- out_sum, out, ACC_WIDTH: signed block sum (integer units).
- out_scale, out, 10: signed combined exponent = w_scale + a_scale - 254.
- out_nan, out, 1: either block scale was 0xFF.
- out_ovf, out, 1: accumulator saturated during this block.

Behaviour:
- Reset (reset low, async):
  - All outputs 0, element counter 0, pipeline valids 0, accumulator 0.
  - A reset mid-block discards the partial block; no out_valid is produced for it.
- Element decode:
  - exp==0: frac={0,man}, shift=0.
  - Otherwise: frac={1,man}, shift=exp-1.
  - Product magnitude = (frac_w*frac_a) << (shift_w+shift_a), PROD_WIDTH bits.
  - Sign = sign_w ^ sign_a; the product is converted to two's complement before accumulation.
  - Block real value = out_sum * 2^(out_scale + 2*(1-BIAS) - 2*MAN_WIDTH).
- Pipeline (two stages):
  - S1 registers the elements when in_valid, plus first/last tags from the element counter.
  - S2 computes the product and accumulates.
  - Element accepted at edge t reaches the accumulator at edge t+2.
- Element counter:
  - Increments per accepted element; wraps BLOCK_SIZE-1 -> 0.
  - in_valid low holds the counter and pipeline contents (gaps allowed anywhere in a block).
- Scales:
  - Sampled only with the element whose count==0; ignored for other elements.
  - Held in a per-block register travelling with the first tag.
- Accumulation:
  - A first-tagged product loads the accumulator (acc = product) rather than adding, so blocks may be back-to-back with no bubble.
  - Addition saturates to the signed ACC_WIDTH min/max.
  - Any saturation sets a sticky per-block overflow bit, cleared by the next first-tagged product.
- Output:
  - When the last-tagged product is accumulated at edge t+2, the same edge loads out_sum, out_scale, out_nan, out_ovf and sets out_valid for exactly one cycle.
  - Outputs hold until the next block completes.
  - out_sum/out_scale are not masked when out_nan=1.
- clear:
  - Counter 0, S1/S2 valids 0, overflow bit 0.
  - Output registers untouched; out_valid forced 0 that cycle.
  - clear with in_valid in the same cycle: clear wins, the element is dropped.
- Simultaneous events:
  - A last element of block N and the first element of block N+1 on consecutive cycles produce correct independent results; out_valid for N occurs while N+1 accumulates.

Test Plan:
- Sum and saturation (E2M1, BLOCK_SIZE=4):
  - ACC_WIDTH=16, 4x (6.0 * 6.0) (elem 0_11_1), scales 127/127 -> one out_valid 2 cycles after last element, out_sum=576, out_scale=0, out_ovf=0.
  - Same stimulus with ACC_WIDTH=10 -> out_sum=511, out_ovf=1.
- Signs and subnormals: pairs 6*6, -6*6, 1*1, 0.5*1 (0_00_1 subnormal) -> out_sum=6 (real 1.5), out_nan=0.
- Scales sampled on first element only:
  - Block 1 scales 130/120, later elements drive 0xFF -> out_scale=-4, out_nan=0.
  - Block 2 w_scale=0xFF on first element -> out_nan=1.
- Gaps and back-to-back:
  - Block 1 with in_valid low for 3 random cycles mid-block, then block 2 immediately after -> two out_valid pulses with the correct independent sums; busy low only between blocks.
- Abort:
  - clear after 2 of 4 elements, then a full block of 1.0*1.0 -> out_sum=16 (4x4), no pulse for the aborted block.
  - reset low mid-block -> all outputs 0 asynchronously; next full block is correct.
